// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: frame layout, command codes and FSM states for the DAC SPI receiver.
package dac_spi_pkg;

  localparam int FRAME_BITS = 24;

  // Bit positions of the fields inside the last FRAME_BITS received bits
  localparam int COMM_MSB = 23;
  localparam int COMM_LSB = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [3:0] CMD_WRITE = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

endpackage

// File: rtl/dac_spi_sync.sv
// dac_spi_sync: single-bit multi-flop synchronizer with a selectable reset value.
module dac_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: SPI-style DAC command receiver (sclk idles high, sync active-low,
// data MSB first, sampled on sclk rising edges). Frames of 24 bits, or 25 with a
// leading pad bit, are decoded into comm/addr/data fields.
// Optional register bank: define DAC_SPI_RX_REGFILE_EN.
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_sync,
  input  logic        spi_data,
  output logic [3:0]  rx_comm,
  output logic [3:0]  rx_addr,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic        busy,
  output logic [15:0] frame_cnt,
  input  logic [3:0]  reg_raddr,
  output logic [15:0] reg_rdata
);

  localparam logic [7:0] SETTLE = 8'(SYNC_STAGES);

  logic sclk_s, sync_s, data_s;
  logic sclk_h_q, sync_h_q;

  dac_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(spi_sclk), .q_o(sclk_s));
  dac_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync (
    .clk(clk), .rst_n(rst_n), .d_i(spi_sync), .q_o(sync_s));
  dac_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d_i(spi_data), .q_o(data_s));

  wire sclk_rise = sclk_s & ~sclk_h_q;
  wire sync_fall = ~sync_s & sync_h_q;
  wire sync_rise = sync_s & ~sync_h_q;

  state_e      state_q;
  logic [23:0] shreg_q;
  logic [5:0]  bitcnt_q;
  logic [31:0] tmo_q;
  logic        pend_q;
  logic        armed_q;
  logic [7:0]  settle_q;
  logic [3:0]  comm_q, addr_q;
  logic [15:0] data_q, cnt_q;
  logic        valid_q, err_q, busy_q;

  wire len_ok = (bitcnt_q == 6'd24) || (bitcnt_q == 6'd25);
  wire accept = (state_q == ST_CHECK) && len_ok;

  // Frame FSM, shift register, counters and registered outputs.
  // armed_q blocks frame starts after reset until sync has settled high, so a
  // frame cut by reset (sync still low) cannot restart from the synchronizer's
  // reset-to-1 transient; only a fresh falling edge starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_h_q <= 1'b1;
      sync_h_q <= 1'b1;
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      tmo_q    <= '0;
      pend_q   <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= '0;
      comm_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sclk_h_q <= sclk_s;
      sync_h_q <= sync_s;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      if (!armed_q) begin
        if (settle_q != SETTLE) settle_q <= settle_q + 8'd1;
        else if (sync_s)        armed_q  <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          pend_q <= 1'b0;
          if (armed_q && (sync_fall || (pend_q && !sync_s))) begin
            state_q  <= ST_SHIFT;
            busy_q   <= 1'b1;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            tmo_q    <= '0;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            shreg_q <= {shreg_q[22:0], data_s};
            if (bitcnt_q != 6'd63) bitcnt_q <= bitcnt_q + 6'd1;
          end
          if (sync_rise)             state_q <= ST_CHECK;
          else if (tmo_q == TIMEOUT) state_q <= ST_ABORT;
          else                       tmo_q   <= tmo_q + 32'd1;
        end
        ST_CHECK: begin
          if (len_ok) begin
            comm_q  <= shreg_q[COMM_MSB:COMM_LSB];
            addr_q  <= shreg_q[ADDR_MSB:ADDR_LSB];
            data_q  <= shreg_q[DATA_MSB:DATA_LSB];
            cnt_q   <= cnt_q + 16'd1;
            valid_q <= 1'b1;
          end else begin
            err_q   <= 1'b1;
          end
          if (sync_fall) pend_q <= 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_ABORT: begin
          err_q <= 1'b1;
          if (sync_fall) pend_q <= 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_comm   = comm_q;
  assign rx_addr   = addr_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_err    = err_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;

`ifdef DAC_SPI_RX_REGFILE_EN
  logic [15:0] bank_q [16];

  // Accepted write commands land in the bank at the frame's address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank_q[i] <= '0;
    end else if (accept && shreg_q[COMM_MSB:COMM_LSB] == CMD_WRITE) begin
      bank_q[shreg_q[ADDR_MSB:ADDR_LSB]] <= shreg_q[DATA_MSB:DATA_LSB];
    end
  end

  assign reg_rdata = bank_q[reg_raddr];
`else
  logic unused_rd;
  assign unused_rd = accept ^ (^reg_raddr);
  assign reg_rdata = 16'h0000;
`endif

endmodule

// File: doc/dac_spi_rx.md
DAC_SPI_RX -- requirements
Module: dac_spi_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on spi_sclk, spi_sync and spi_data (minimum 2).
REQ-002 SHALL have parameter TIMEOUT, default 32'd4096, meaning the maximum clk cycles spi_sync may stay low before the frame is aborted.
REQ-003 SHALL have port clk, input, 1 bit: system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port spi_sclk, input, 1 bit: serial clock; idles high.
REQ-006 SHALL have port spi_sync, input, 1 bit: frame select; active-low.
REQ-007 SHALL have port spi_data, input, 1 bit: serial data, MSB first.
REQ-008 SHALL have ports rx_comm [3:0], rx_addr [3:0] and rx_data [15:0], outputs: fields of the last good frame.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a good frame is decoded.
REQ-010 SHALL have port rx_err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port frame_cnt, output, 16 bits: count of good frames; wraps from 16'hFFFF to 0.
REQ-013 SHALL have port reg_raddr, input, 4 bits, and port reg_rdata, output, 16 bits: register bank read port.

Function
REQ-014 SHALL pass spi_sclk, spi_sync and spi_data through SYNC_STAGES flops, plus one history flop on spi_sclk and spi_sync for edge detection.
REQ-015 SHALL implement FSM IDLE -> SHIFT on a synchronized spi_sync falling edge; SHIFT -> CHECK on a spi_sync rising edge; SHIFT -> ABORT when the timeout counter reaches TIMEOUT; CHECK -> IDLE and ABORT -> IDLE after one cycle each.
REQ-016 In SHIFT, each synchronized spi_sclk rising edge SHALL shift the synchronized spi_data into a 24-bit shift register and increment a 6-bit bit counter, which saturates at 63.
REQ-017 CHECK SHALL accept the frame only when the bit count is 24 or 25 (25 allows a leading pad bit); the last 24 bits map to comm[23:20], addr[19:16] and data[15:0].
REQ-018 On accept: rx_comm, rx_addr and rx_data SHALL update, rx_valid SHALL pulse and frame_cnt SHALL increment, all in the cycle after CHECK, i.e. two clk cycles after the sync rising edge is detected.
REQ-019 On any other count, and in ABORT, rx_err SHALL pulse one cycle, with rx_* fields and frame_cnt unchanged.
REQ-020 A spi_sclk edge while in IDLE SHALL be ignored, and a spi_sync falling edge while in CHECK or ABORT SHALL be honoured on return to IDLE only if spi_sync is still low; otherwise it is dropped.
REQ-021 busy SHALL be high in SHIFT, CHECK and ABORT.
REQ-022 rx_valid and rx_err SHALL never be high in the same cycle.

Reset
REQ-023 rst_n low SHALL asynchronously force: FSM to IDLE; sclk/sync synchronizers to 1; data synchronizer to 0; shift register, counters, rx_comm, rx_addr, rx_data, frame_cnt and the register bank to 0; rx_valid, rx_err and busy to 0.
REQ-024 Reset asserted mid-frame SHALL discard the frame without an rx_err pulse, and after release the block SHALL wait for a fresh spi_sync falling edge.

Configuration
REQ-025 With DAC_SPI_RX_REGFILE_EN defined, a 16x16 register bank SHALL be written with rx_data at index rx_addr on each accepted frame whose comm equals CMD_WRITE (4'h3), and reg_rdata SHALL be the bank entry at reg_raddr (combinational).
REQ-026 Without DAC_SPI_RX_REGFILE_EN, no bank SHALL be built and reg_rdata SHALL be tied to 16'h0000.

Structure
REQ-027 Package dac_spi_pkg SHALL hold FRAME_BITS (24), the field bit positions, CMD_WRITE, and the FSM state enum.
REQ-028 Sub-module dac_spi_sync SHALL implement one parameterized synchronizer bit with a reset value parameter and SHALL be instantiated three times.

Verification
REQ-029 Frame: comm=3, addr=5, data=16'hBEEF, sclk half-period of 16 clk, 25 bits including a leading 0 -> rx_valid pulses once; rx_comm=3, rx_addr=5, rx_data=16'hBEEF, frame_cnt=1.
REQ-030 Frame of only 20 bits -> rx_err pulses once; rx_* fields and frame_cnt unchanged.
REQ-031 spi_sync held low with no sclk activity for 4096 cycles -> ABORT, rx_err pulses, busy falls.
REQ-032 rst_n pulsed after bit 12 of a frame, then a good frame sent -> no rx_err; the second frame decodes correctly.
REQ-033 With REGFILE enabled: write addr=9, data=16'h1234 with comm=3, then a frame with comm=1 to addr=9 data=16'h0000 -> reg_rdata at reg_raddr=9 reads 16'h1234; without the macro it reads 16'h0000.
REQ-034 65536 good frames -> frame_cnt wraps to 0.
